// File: rtl/m5_ar_sched.sv
// m5_ar_sched: AXI AR scheduler between one host stream and MIG_GRP_SIZE migration streams
module m5_ar_sched #(
  parameter int MIG_GRP_SIZE    = 2,
  parameter int ADDR_W          = 34,
  parameter int ARID_W          = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int HOST_BURST      = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_W-1:0]              host_araddr,
  input  logic                           host_arvalid,
  output logic                           host_arready,
  input  logic [MIG_GRP_SIZE*ADDR_W-1:0] mig_araddr,
  input  logic [MIG_GRP_SIZE-1:0]        mig_arvalid,
  output logic [MIG_GRP_SIZE-1:0]        mig_arready,
  output logic [ADDR_W-1:0]              m_araddr,
  output logic [ARID_W-1:0]              m_arid,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  input  logic [ARID_W-1:0]              m_rid,
  input  logic                           m_rvalid,
  input  logic                           m_rready,
  input  logic                           m_rlast,
  output logic                           idle
);
  localparam int N  = MIG_GRP_SIZE;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int HW = $clog2(HOST_BURST + 1);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  logic [CW-1:0] cnt    [N+1];
  logic [CW-1:0] cnt_nx [N+1];
  logic [HW-1:0] hcnt, hcnt_nx;
  logic [PW-1:0] ptr, mig_sel;
  logic [N:0]    elig, grant, done;
  logic          slot_free, mig_any, host_win, found, arvalid_nx, zero_nx;
  int            idx;
  // eligibility, host-vs-migration arbitration, round-robin pick and next-state values
  always_comb begin
    slot_free = !m_arvalid || m_arready;
    elig[0] = host_arvalid && cnt[0] < CW'(MAX_OUTSTANDING);
    for (int r = 1; r <= N; r++) elig[r] = mig_arvalid[r-1] && cnt[r] < CW'(MAX_OUTSTANDING);
    mig_any = |elig[N:1];
    host_win = elig[0] && !(mig_any && hcnt == HW'(HOST_BURST));
    mig_sel = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && elig[idx+1]) begin
        mig_sel = PW'(idx);
        found = 1'b1;
      end
    end
    grant = '0;
    if (slot_free && reset_n) begin
      grant[0] = host_win;
      if (!host_win && mig_any) grant[int'(mig_sel)+1] = 1'b1;
    end
    zero_nx = 1'b1;
    for (int r = 0; r <= N; r++) begin
      done[r] = m_rvalid && m_rready && m_rlast && m_rid == ARID_W'(r);
      cnt_nx[r] = (grant[r] && !done[r]) ? cnt[r] + CW'(1) :
                  (done[r] && !grant[r] && cnt[r] != '0) ? cnt[r] - CW'(1) : cnt[r];
      zero_nx = zero_nx && cnt_nx[r] == '0;
    end
    arvalid_nx = |grant || (m_arvalid && !m_arready);
    hcnt_nx = (grant[0] && mig_any) ? hcnt + HW'(1) : (|grant[N:1] || !mig_any) ? '0 : hcnt;
  end
  assign host_arready = grant[0];
  assign mig_arready  = grant[N:1];
  // holding register, arbitration state, per-ID outstanding counters and idle flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arid    <= '0;
      hcnt      <= '0;
      ptr       <= PW'(N - 1);
      idle      <= 1'b1;
      for (int r = 0; r <= N; r++) cnt[r] <= '0;
    end else begin
      m_arvalid <= arvalid_nx;
      if (|grant) begin
        m_araddr <= grant[0] ? host_araddr : mig_araddr[int'(mig_sel)*ADDR_W +: ADDR_W];
        m_arid   <= grant[0] ? '0 : ARID_W'(int'(mig_sel) + 1);
      end
      if (|grant[N:1]) ptr <= mig_sel;
      hcnt <= hcnt_nx;
      idle <= !arvalid_nx && zero_nx;
      cnt  <= cnt_nx;
    end
endmodule

// File: tb/tb_m5_ar_sched.sv
// tb_m5_ar_sched: randomized scoreboard bench for the AR scheduler against a behavioural model
module tb_m5_ar_sched;
  localparam int N = 2, AW = 34, IW = 4, MO = 3, HB = 4;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  logic [AW-1:0]   host_araddr, m_araddr;
  logic            host_arvalid, host_arready, m_arvalid, m_arready;
  logic [N*AW-1:0] mig_araddr;
  logic [N-1:0]    mig_arvalid, mig_arready;
  logic [IW-1:0]   m_arid, m_rid;
  logic            m_rvalid, m_rready, m_rlast, idle;
  m5_ar_sched #(.MIG_GRP_SIZE(N), .ADDR_W(AW), .ARID_W(IW), .MAX_OUTSTANDING(MO), .HOST_BURST(HB)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_araddr(host_araddr), .host_arvalid(host_arvalid), .host_arready(host_arready),
    .mig_araddr(mig_araddr), .mig_arvalid(mig_arvalid), .mig_arready(mig_arready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .idle(idle)
  );
  typedef struct packed {logic [IW-1:0] id; logic [AW-1:0] addr;} ar_t;
  ar_t q[$];
  int checks = 0, passes = 0;
  int out_m[N+1];
  int hc_m, last_m, slot_m;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic model_reset();
    for (int r = 0; r <= N; r++) out_m[r] = 0;
    hc_m = 0;
    last_m = N - 1;
    slot_m = 0;
    q.delete();
  endtask
  function automatic logic [AW-1:0] rnd_addr();
    return AW'({$urandom, $urandom});
  endfunction
  task automatic step(input int pv, input int par, input int pr);
    bit idle_exp, any, done;
    bit me[N];
    int w, g;
    logic [N:0] expv;
    @(negedge clk);
    idle_exp = slot_m == 0;
    for (int r = 0; r <= N; r++) if (out_m[r] != 0) idle_exp = 0;
    chk("idle", idle, idle_exp);
    host_arvalid = $urandom_range(99) < pv;
    host_araddr = rnd_addr();
    for (int i = 0; i < N; i++) begin
      mig_arvalid[i] = $urandom_range(99) < pv;
      mig_araddr[i*AW +: AW] = rnd_addr();
    end
    m_arready = $urandom_range(99) < par;
    m_rvalid = $urandom_range(99) < pr;
    m_rready = $urandom_range(9) != 0;
    m_rlast = $urandom_range(3) != 0;
    m_rid = ($urandom_range(9) == 0) ? IW'(7) : IW'($urandom_range(N));
    #1;
    any = 0;
    for (int i = 0; i < N; i++) begin
      me[i] = mig_arvalid[i] && out_m[i+1] < MO;
      any = any | me[i];
    end
    w = -1;
    if (!slot_m || m_arready) begin
      if (host_arvalid && out_m[0] < MO && !(any && hc_m == HB)) w = 0;
      else if (any)
        for (int k = 1; k <= N; k++) begin
          g = (last_m + k) % N;
          if (w < 0 && me[g]) w = g + 1;
        end
    end
    expv = '0;
    if (w >= 0) expv[w] = 1'b1;
    chk("arready", {mig_arready, host_arready}, expv);
    if (w >= 0) q.push_back(ar_t'{IW'(w), (w == 0) ? host_araddr : mig_araddr[(w-1)*AW +: AW]});
    if (w == 0) hc_m = any ? hc_m + 1 : 0;
    else if (w > 0 || !any) hc_m = 0;
    if (w > 0) last_m = w - 1;
    done = m_rvalid && m_rready && m_rlast && m_rid <= N;
    for (int r = 0; r <= N; r++) begin
      if (w == r) out_m[r]++;
      if (done && int'(m_rid) == r && out_m[r] > 0) out_m[r]--;
    end
    slot_m = (w >= 0) ? 1 : (m_arready ? 0 : slot_m);
  endtask
  task automatic do_reset();
    host_arvalid = 1;
    mig_arvalid = '1;
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arid", m_arid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_arready", {mig_arready, host_arready}, 0);
    host_arvalid = 0;
    mig_arvalid = '0;
    m_rvalid = 0;
    repeat (2) @(negedge clk);
    model_reset();
    reset_n = 1;
  endtask
  // monitor: pop the expected request on every AR handshake
  initial forever begin
    ar_t e;
    @(negedge clk);
    #2;
    if (reset_n && m_arvalid && m_arready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL ar_unexpected: got id %0h addr %0h expected no request", m_arid, m_araddr);
      end else begin
        e = q.pop_front();
        chk("arid", m_arid, e.id);
        chk("araddr", m_araddr, e.addr);
      end
    end
  end
  initial begin
    host_araddr = '0;
    host_arvalid = 1;
    mig_araddr = '0;
    mig_arvalid = '1;
    m_arready = 1;
    m_rid = '0;
    m_rvalid = 0;
    m_rready = 0;
    m_rlast = 0;
    model_reset();
    #12;
    chk("init_idle", idle, 1);
    chk("init_arvalid", m_arvalid, 0);
    chk("init_arready", {mig_arready, host_arready}, 0);
    host_arvalid = 0;
    mig_arvalid = '0;
    @(negedge clk);
    reset_n = 1;
    repeat (60) step(100, 100, 60);
    repeat (8) step(100, 0, 0);
    do_reset();
    repeat (400) step(70, 70, 40);
    repeat (8) step(100, 0, 30);
    do_reset();
    repeat (400) step(50, 80, 30);
    repeat (20) step(0, 100, 0);
    chk("queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
